// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder/subtractor: the operands are split into CHUNK-bit slices
// and one slice is added per clock, LSB slice first, behind a valid/ready handshake.
module add_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             c_out_c;
    logic             c_msb_c;
    logic             last;

    // Ripple add of one slice; returns {carry into top bit, carry out, sum bits}.
    function automatic logic [CHUNK+1:0] add_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c0
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] s;
        logic             c;
        logic             c_msb;
        g     = x & y;
        p     = x ^ y;
        s     = '0;
        c     = c0;
        c_msb = c0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = p[i] ^ c;
            if (i == CHUNK - 1) begin
                c_msb = c;
            end
            c = g[i] | (p[i] & c);
        end
        return {c_msb, c, s};
    endfunction

    assign last = (cnt == LAST);

    // Slice select, slice add and in-place write-back of the slice result.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                a_c = a_r[k*CHUNK +: CHUNK];
                b_c = b_r[k*CHUNK +: CHUNK];
            end
        end
        {c_msb_c, c_out_c, s_c} = add_chunk(a_c, b_c, carry);
        sum_nxt = sum_r;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                sum_nxt[k*CHUNK +: CHUNK] = s_c;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Subtraction is A + ~B + 1, so the inversion and forced carry happen at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= sub ? ~b : b;
                        carry  <= sub ? 1'b1 : cin;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                        zero_r <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r <= sum_nxt;
                    carry <= c_out_c;
                    if (last) begin
                        cout_r <= c_out_c;
                        ovf_r  <= c_msb_c ^ c_out_c;
                        zero_r <= (sum_nxt == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule
